// File: rtl/obb_pkg.sv
// obb_pkg: shared widths, FSM states and helpers for the OBB motion integrator.
package obb_pkg;

    localparam int POS_W    = 24;
    localparam int VEL_W    = 16;
    localparam int ANG_W    = 16;
    localparam int DIM_W    = 8;
    localparam int MASS_W   = 16;
    localparam int POS_FRAC = 8;
    localparam int VEL_FRAC = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEL,
        S_POS,
        S_WALL,
        S_ANG,
        S_LOAD
    } state_e;

    // Fields that ride through the integrator untouched.
    typedef struct packed {
        logic [ANG_W-1:0]  omega;
        logic [DIM_W-1:0]  width;
        logic [DIM_W-1:0]  height;
        logic [MASS_W-1:0] inv_mass;
        logic [MASS_W-1:0] inertia;
        logic [MASS_W-1:0] inv_inertia;
    } pass_t;

    function automatic logic signed [VEL_W-1:0] sat16(input logic signed [VEL_W+1:0] v);
        return (v > 18'sd32767)  ? 16'sh7fff :
               (v < -18'sd32768) ? 16'sh8000 : v[VEL_W-1:0];
    endfunction

endpackage

// File: rtl/obb_wall_clamp.sv
// obb_wall_clamp: single-axis wall clamp; outside a wall the position snaps to it
// and velocity reflects with saturating negation.
module obb_wall_clamp
    import obb_pkg::*;
(
    input  logic signed [POS_W-1:0] pos_i,
    input  logic signed [VEL_W-1:0] vel_i,
    input  logic signed [POS_W-1:0] min_i,
    input  logic signed [POS_W-1:0] max_i,
    output logic signed [POS_W-1:0] pos_o,
    output logic signed [VEL_W-1:0] vel_o
);

    logic signed [VEL_W-1:0] vel_neg;
    logic                    lo, hi;

    assign vel_neg = (vel_i == 16'sh8000) ? 16'sh7fff : -vel_i;
    assign lo      = pos_i < min_i;
    assign hi      = pos_i > max_i;
    assign pos_o   = lo ? min_i : hi ? max_i : pos_i;
    assign vel_o   = (lo || hi) ? vel_neg : vel_i;

endmodule

// File: rtl/obb_integrator.sv
// obb_integrator: per-frame semi-implicit Euler step with wall bounce and angle
// advance, feeding the OBB register's parallel-load bus.
module obb_integrator
    import obb_pkg::*;
#(
    parameter int GRAVITY    = 16,
    parameter int DAMP_SHIFT = 0,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 639,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 479
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    input  logic                     en,
    input  logic signed [POS_W-1:0]  pos_x,
    input  logic signed [POS_W-1:0]  pos_y,
    input  logic signed [VEL_W-1:0]  vel_x,
    input  logic signed [VEL_W-1:0]  vel_y,
    input  logic [ANG_W-1:0]         angle,
    input  logic [ANG_W-1:0]         omega,
    input  logic [DIM_W-1:0]         width,
    input  logic [DIM_W-1:0]         height,
    input  logic [MASS_W-1:0]        inv_mass,
    input  logic [MASS_W-1:0]        inertia,
    input  logic [MASS_W-1:0]        inv_inertia,
    output logic signed [POS_W-1:0]  ld_pos_x,
    output logic signed [POS_W-1:0]  ld_pos_y,
    output logic signed [VEL_W-1:0]  ld_vel_x,
    output logic signed [VEL_W-1:0]  ld_vel_y,
    output logic [ANG_W-1:0]         ld_angle,
    output logic [ANG_W-1:0]         ld_omega,
    output logic [DIM_W-1:0]         ld_width,
    output logic [DIM_W-1:0]         ld_height,
    output logic [MASS_W-1:0]        ld_inv_mass,
    output logic [MASS_W-1:0]        ld_inertia,
    output logic [MASS_W-1:0]        ld_inv_inertia,
    output logic                     load,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic signed [POS_W-1:0] XLO = POS_W'(X_MIN * (1 << POS_FRAC));
    localparam logic signed [POS_W-1:0] XHI = POS_W'(X_MAX * (1 << POS_FRAC));
    localparam logic signed [POS_W-1:0] YLO = POS_W'(Y_MIN * (1 << POS_FRAC));
    localparam logic signed [POS_W-1:0] YHI = POS_W'(Y_MAX * (1 << POS_FRAC));
    localparam logic signed [VEL_W+1:0] G18 = (VEL_W+2)'(GRAVITY);

    state_e                  state_q, state_d;
    logic signed [POS_W-1:0] px_q, px_d, py_q, py_d;
    logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic [ANG_W-1:0]        ang_q, ang_d;
    pass_t                   pas_q, pas_d;
    logic                    ovr_q, ovr_d;

    logic signed [VEL_W+1:0] vx_e, vy_e, vx_v, vy_v;
    logic signed [POS_W-1:0] wpx, wpy;
    logic signed [VEL_W-1:0] wvx, wvy;

    // Two guard bits keep damping plus gravity exact before saturation.
    assign vx_e = {{2{vx_q[VEL_W-1]}}, vx_q};
    assign vy_e = {{2{vy_q[VEL_W-1]}}, vy_q};
    assign vx_v = vx_e - ((DAMP_SHIFT != 0) ? (vx_e >>> DAMP_SHIFT) : '0);
    assign vy_v = vy_e - ((DAMP_SHIFT != 0) ? (vy_e >>> DAMP_SHIFT) : '0) + G18;

    obb_wall_clamp u_wall_x (
        .pos_i(px_q), .vel_i(vx_q), .min_i(XLO), .max_i(XHI), .pos_o(wpx), .vel_o(wvx)
    );

    obb_wall_clamp u_wall_y (
        .pos_i(py_q), .vel_i(vy_q), .min_i(YLO), .max_i(YHI), .pos_o(wpy), .vel_o(wvy)
    );

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        ang_d   = ang_q;
        pas_d   = pas_q;
        ovr_d   = ovr_q | (step && state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: if (step && en) begin
                state_d = S_VEL;
                px_d    = pos_x;
                py_d    = pos_y;
                vx_d    = vel_x;
                vy_d    = vel_y;
                ang_d   = angle;
                pas_d   = '{omega, width, height, inv_mass, inertia, inv_inertia};
            end
            S_VEL: begin
                state_d = S_POS;
                vx_d    = sat16(vx_v);
                vy_d    = sat16(vy_v);
            end
            S_POS: begin
                state_d = S_WALL;
                px_d    = px_q + {{(POS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
                py_d    = py_q + {{(POS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
            end
            S_WALL: begin
                state_d = S_ANG;
                px_d    = wpx;
                py_d    = wpy;
                vx_d    = wvx;
                vy_d    = wvy;
            end
            S_ANG: begin
                state_d = S_LOAD;
                ang_d   = ang_q + pas_q.omega;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            ang_q   <= '0;
            pas_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            ang_q   <= ang_d;
            pas_q   <= pas_d;
            ovr_q   <= ovr_d;
        end
    end

    assign load           = state_q == S_LOAD;
    assign busy           = state_q != S_IDLE;
    assign overrun        = ovr_q;
    assign ld_pos_x       = px_q;
    assign ld_pos_y       = py_q;
    assign ld_vel_x       = vx_q;
    assign ld_vel_y       = vy_q;
    assign ld_angle       = ang_q;
    assign ld_omega       = pas_q.omega;
    assign ld_width       = pas_q.width;
    assign ld_height      = pas_q.height;
    assign ld_inv_mass    = pas_q.inv_mass;
    assign ld_inertia     = pas_q.inertia;
    assign ld_inv_inertia = pas_q.inv_inertia;

endmodule

// File: tb/tb_obb_integrator.sv
// tb_obb_integrator: directed vectors for obb_integrator; a second instance
// with DAMP_SHIFT=2 covers damping.
module tb_obb_integrator;

    logic        clk, reset, step, en;
    logic [23:0] pos_x, pos_y;
    logic [15:0] vel_x, vel_y, angle, omega, inv_mass, inertia, inv_inertia;
    logic [7:0]  width, height;

    logic [23:0] ld_pos_x, ld_pos_y;
    logic [15:0] ld_vel_x, ld_vel_y, ld_angle, ld_omega, ld_inv_mass, ld_inertia, ld_inv_inertia;
    logic [7:0]  ld_width, ld_height;
    logic        load, busy, overrun;

    logic [23:0] d_pos_x, d_pos_y;
    logic [15:0] d_vel_x, d_vel_y, d_angle, d_omega, d_inv_mass, d_inertia, d_inv_inertia;
    logic [7:0]  d_width, d_height;
    logic        d_load, d_busy, d_overrun;

    int n_chk = 0;
    int n_err = 0;

    obb_integrator u_dut (
        .clk(clk), .reset(reset), .step(step), .en(en),
        .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
        .angle(angle), .omega(omega), .width(width), .height(height),
        .inv_mass(inv_mass), .inertia(inertia), .inv_inertia(inv_inertia),
        .ld_pos_x(ld_pos_x), .ld_pos_y(ld_pos_y), .ld_vel_x(ld_vel_x), .ld_vel_y(ld_vel_y),
        .ld_angle(ld_angle), .ld_omega(ld_omega), .ld_width(ld_width), .ld_height(ld_height),
        .ld_inv_mass(ld_inv_mass), .ld_inertia(ld_inertia), .ld_inv_inertia(ld_inv_inertia),
        .load(load), .busy(busy), .overrun(overrun)
    );

    obb_integrator #(.DAMP_SHIFT(2)) u_damp (
        .clk(clk), .reset(reset), .step(step), .en(en),
        .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
        .angle(angle), .omega(omega), .width(width), .height(height),
        .inv_mass(inv_mass), .inertia(inertia), .inv_inertia(inv_inertia),
        .ld_pos_x(d_pos_x), .ld_pos_y(d_pos_y), .ld_vel_x(d_vel_x), .ld_vel_y(d_vel_y),
        .ld_angle(d_angle), .ld_omega(d_omega), .ld_width(d_width), .ld_height(d_height),
        .ld_inv_mass(d_inv_mass), .ld_inertia(d_inertia), .ld_inv_inertia(d_inv_inertia),
        .load(d_load), .busy(d_busy), .overrun(d_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [23:0] px, input logic [23:0] py, input logic [15:0] vx,
                          input logic [15:0] vy, input logic [15:0] an, input logic [15:0] om);
        pos_x = px; pos_y = py; vel_x = vx; vel_y = vy; angle = an; omega = om;
    endtask

    // Called at a falling edge; returns at a falling edge with ld_* settled.
    task automatic run_step(input string tag);
        int first = 0;
        int n     = 0;
        step = 1'b1;
        en   = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (load) begin
                n++;
                if (first == 0) first = i;
            end
            chk({tag, "_busy"}, 32'(busy), (i <= 5) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk({tag, "_load_cycle"}, first, 5);
        chk({tag, "_load_count"}, n, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1; step = 1'b0; en = 1'b1;
        width = 8'h12; height = 8'h34;
        inv_mass = 16'h1111; inertia = 16'h2222; inv_inertia = 16'h3333;
        set_in(24'h002000, 24'h002000, 16'h0180, 16'h0000, 16'h1234, 16'h0000);
        #1;
        chk("rst_load", 32'(load), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_ld_pos_x", 32'(ld_pos_x), 0);
        chk("rst_ld_width", 32'(ld_width), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Free motion plus gravity
        run_step("t1");
        chk("t1_vel_x", 32'(ld_vel_x), 32'h0180);
        chk("t1_pos_x", 32'(ld_pos_x), 32'h002180);
        chk("t1_vel_y", 32'(ld_vel_y), 32'h0010);
        chk("t1_pos_y", 32'(ld_pos_y), 32'h002010);
        chk("t1_angle", 32'(ld_angle), 32'h1234);
        chk("t1_omega", 32'(ld_omega), 32'h0000);
        chk("t1_width", 32'(ld_width), 32'h12);
        chk("t1_height", 32'(ld_height), 32'h34);
        chk("t1_inv_mass", 32'(ld_inv_mass), 32'h1111);
        chk("t1_inertia", 32'(ld_inertia), 32'h2222);
        chk("t1_inv_inertia", 32'(ld_inv_inertia), 32'h3333);
        chk("t1_overrun", 32'(overrun), 0);

        // Walls
        set_in(24'h027F00, 24'h002000, 16'h0200, 16'h0000, 16'h0000, 16'h0000);
        run_step("t2a");
        chk("t2a_pos_x", 32'(ld_pos_x), 32'h027F00);
        chk("t2a_vel_x", 32'(ld_vel_x), 32'hFE00);
        set_in(24'h000080, 24'h002000, 16'hFF00, 16'h0000, 16'h0000, 16'h0000);
        run_step("t2b");
        chk("t2b_pos_x", 32'(ld_pos_x), 32'h000000);
        chk("t2b_vel_x", 32'(ld_vel_x), 32'h0100);
        set_in(24'h027E00, 24'h002000, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        run_step("t2c");
        chk("t2c_on_wall_pos", 32'(ld_pos_x), 32'h027F00);
        chk("t2c_on_wall_vel", 32'(ld_vel_x), 32'h0100);
        set_in(24'h000000, 24'h002000, 16'h8000, 16'h0000, 16'h0000, 16'h0000);
        run_step("t2d");
        chk("t2d_neg_sat_pos", 32'(ld_pos_x), 32'h000000);
        chk("t2d_neg_sat_vel", 32'(ld_vel_x), 32'h7FFF);
        set_in(24'h002000, 24'h01DF80, 16'h0000, 16'h0100, 16'h0000, 16'h0000);
        run_step("t2e");
        chk("t2e_floor_pos_y", 32'(ld_pos_y), 32'h01DF00);
        chk("t2e_floor_vel_y", 32'(ld_vel_y), 32'hFEF0);

        // Angle wrap
        set_in(24'h002000, 24'h002000, 16'h0000, 16'h0000, 16'hFFF0, 16'h0020);
        run_step("t3");
        chk("t3_angle", 32'(ld_angle), 32'h0010);
        chk("t3_omega", 32'(ld_omega), 32'h0020);

        // Saturation and damping
        set_in(24'h002000, 24'h002000, 16'h0400, 16'h7FF8, 16'h0000, 16'h0000);
        run_step("t4");
        chk("t4_vel_y_sat", 32'(ld_vel_y), 32'h7FFF);
        chk("t4_pos_y", 32'(ld_pos_y), 32'h009FFF);
        chk("t4_damp_vel_x", 32'(d_vel_x), 32'h0300);
        chk("t4_damp_pos_x", 32'(d_pos_x), 32'h002300);

        // Overrun: extra steps while busy and during LOAD
        set_in(24'h002000, 24'h002000, 16'h0180, 16'h0000, 16'h1234, 16'h0000);
        n = 0;
        step = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 12; i++) begin
            if (load) n++;
            step = (i == 2 || i == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        chk("t5_load_count", n, 1);
        chk("t5_overrun", 32'(overrun), 1);
        en = 1'b0;
        step = 1'b1;
        n = 0;
        @(negedge clk);
        step = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (load || busy) n++;
            @(negedge clk);
        end
        chk("t5_en0_activity", n, 0);
        chk("t5_en0_overrun", 32'(overrun), 1);
        en = 1'b1;

        // Async reset in WALL
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_load", 32'(load), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_overrun", 32'(overrun), 0);
        chk("t6_ld_pos_x", 32'(ld_pos_x), 0);
        chk("t6_ld_vel_x", 32'(ld_vel_x), 0);
        chk("t6_ld_width", 32'(ld_width), 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            if (load) n++;
            @(negedge clk);
        end
        chk("t6_no_load", n, 0);
        run_step("t6b");
        chk("t6b_pos_x", 32'(ld_pos_x), 32'h002180);
        chk("t6b_vel_y", 32'(ld_vel_y), 32'h0010);
        chk("t6b_overrun", 32'(overrun), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
